bram_line_reader: RTL and testbench

Streaming read-out engine for one cache line held in a dual-port BRAM. On a line request it drives the read-only BRAM port: sequential word addresses, one-cycle read latency absorbed, data delivered on a valid/ready stream with a last-beat flag. It sits between the cache data array and the writeback path (AXI write-data beat generator), and is the read-side initiator for the array.

---
 rtl/bram_line_reader_pkg.sv | 25 ++
 rtl/bram_line_reader_if.sv | 31 +++
 rtl/bram_line_reader_skid_fifo2.sv | 71 +++++++
 rtl/bram_line_reader.sv | 125 ++++++++++++
 tb/tb_bram_line_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_line_reader_pkg.sv
// bram_line_reader_pkg
//   Shared definitions for the BRAM line reader: default geometry, word and
//   address typedefs for that geometry, and the FSM state encoding.
//   The state type is exported on the top-level debug port.
package bram_line_reader_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_LINE_WORDS = 16;
  // Word-offset width within a line for the default geometry.
  localparam int DEF_OFF_W      = $clog2(DEF_LINE_WORDS);
  localparam int DEF_IDX_W      = DEF_ADDR_WIDTH - DEF_OFF_W;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DEF_OFF_W-1:0]      off_t;
  typedef logic [DEF_IDX_W-1:0]      index_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bram_line_reader_if.sv
// bram_line_reader_if
//   Request and beat-stream signals of the line reader.
//   Handshake rule (both channels): a transfer happens on a rising clk edge
//   where valid and ready are both 1. Once out_valid is raised it stays 1,
//   and out_data/out_last stay stable, until the beat is taken.
//   req_valid may be held while req_ready is 0; it is simply not taken.
//   Modports:
//     master : request source and beat sink (writeback path side)
//     slave  : the line reader itself
interface bram_line_reader_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 6
);
  logic                   req_valid;
  logic                   req_ready;
  logic [INDEX_WIDTH-1:0] req_index;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_last;

  modport master (
    output req_valid, req_index, out_ready,
    input  req_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  req_valid, req_index, out_ready,
    output req_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bram_line_reader_skid_fifo2.sv
// skid_fifo2
//   Two-entry register FIFO holding BRAM words between the read port and
//   the output stream.
//   Ports:
//     clk, resetn  clock, synchronous active-low reset (empties the FIFO)
//     push, push_data  write one word
//     pop          remove the head word (ignored when empty)
//     count        occupancy 0..2
//     head         oldest word (entry 0), meaningful when count != 0
//   The caller never pushes into a full FIFO without popping the same cycle.
module skid_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] entry0_q;
  logic [W-1:0] entry1_q;
  logic [1:0]   count_q;
  logic         pop_eff;
  logic         push_eff;

  assign pop_eff  = pop && (count_q != 2'd0);
  assign push_eff = push && ((count_q != 2'd2) || pop_eff);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= 2'd0;
    end else begin
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_ff @(posedge clk) begin
    case ({push_eff, pop_eff})
      2'b10: begin
        if (count_q == 2'd0) entry0_q <= push_data;
        else                 entry1_q <= push_data;
      end
      2'b01: begin
        entry0_q <= entry1_q;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          entry0_q <= push_data;
        end else begin
          entry0_q <= entry1_q;
          entry1_q <= push_data;
        end
      end
      default: begin
        entry0_q <= entry0_q;
      end
    endcase
  end

  assign count = count_q;
  assign head  = entry0_q;

endmodule

// File: rtl/bram_line_reader.sv
// bram_line_reader
//   Reads one cache line out of the read port of a dual-port BRAM and
//   streams it as valid/ready beats with a last-beat flag.
//   Ports:
//     clk, resetn     clock, synchronous active-low reset
//     bus             request + beat stream (slave modport)
//     bram_en         BRAM read enable, high only on issue cycles
//     bram_write_en   byte write enables, always 0 (read-only port)
//     bram_addr       word address {line index, word offset}
//     bram_data_out   BRAM read data, one cycle after bram_en
//     busy            a line is in progress
//     state_dbg       current FSM state
//   Reads are issued only while the 2-entry FIFO can absorb every word
//   already issued, so backpressure never drops or repeats a beat.
module bram_line_reader
  import bram_line_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                    clk,
  input  logic                    resetn,
  bram_line_reader_if.slave       bus,
  output logic                    bram_en,
  output logic [DATA_WIDTH/8-1:0] bram_write_en,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  input  logic [DATA_WIDTH-1:0]   bram_data_out,
  output logic                    busy,
  output state_t                  state_dbg
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [IDX_W-1:0]  index_q;
  logic [OFF_W-1:0]  issue_cnt_q;
  logic [OFF_W-1:0]  beat_cnt_q;
  logic              inflight_q;

  logic [1:0]        fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;

  logic              req_ready_int;
  logic              accept;
  logic              out_valid_int;
  logic              out_last_int;
  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;
  logic [2:0]        limit;

  // Ready is also held low while reset is asserted.
  assign req_ready_int = (state_q == ST_IDLE) && resetn;
  assign accept        = bus.req_valid && req_ready_int;

  assign out_valid_int = (fifo_count != 2'd0);
  assign out_last_int  = out_valid_int && (beat_cnt_q == LAST_OFF);
  assign pop           = out_valid_int && bus.out_ready;

  // Words held + word arriving next edge, minus the one leaving now, must
  // leave room for the word this issue will deliver two edges later.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign limit     = 3'd2 + {2'b00, pop};
  assign issue     = (state_q == ST_READ) && (occupancy < limit);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)                         state_d = ST_READ;
      ST_READ:  if (issue && issue_cnt_q == LAST_OFF) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && out_last_int)            state_d = ST_IDLE;
      default:                                      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (accept) begin
        index_q     <= bus.req_index;
        issue_cnt_q <= '0;
        beat_cnt_q  <= '0;
      end else begin
        if (issue) issue_cnt_q <= issue_cnt_q + 1'b1;
        if (pop)   beat_cnt_q  <= beat_cnt_q + 1'b1;
      end
    end
  end

  skid_fifo2 #(
    .W(DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (inflight_q),
    .push_data (bram_data_out),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign bram_en       = issue;
  assign bram_write_en = '0;
  assign bram_addr     = {index_q, issue_cnt_q};

  assign bus.req_ready = req_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = fifo_head;
  assign bus.out_last  = out_last_int;

  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bram_line_reader.sv
// tb_bram_line_reader
//   Bench for bram_line_reader (32-bit words, 10-bit addresses, 16-word
//   lines) with a one-cycle-latency BRAM model and a beat scoreboard.
module tb_bram_line_reader;
  import bram_line_reader_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int AW = DEF_ADDR_WIDTH;
  localparam int LW = DEF_LINE_WORDS;
  localparam int OW = DEF_OFF_W;
  localparam int IW = DEF_IDX_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  bram_line_reader_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

  logic             bram_en;
  logic [DW/8-1:0]  bram_write_en;
  addr_t            bram_addr;
  word_t            bram_data_out;
  logic             busy;
  state_t           state_dbg;

  bram_line_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LINE_WORDS(LW)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus),
    .bram_en       (bram_en),
    .bram_write_en (bram_write_en),
    .bram_addr     (bram_addr),
    .bram_data_out (bram_data_out),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // ---------------- BRAM model ----------------
  word_t mem [0:(1<<AW)-1];
  always @(posedge clk) if (bram_en) bram_data_out <= mem[bram_addr];

  // ---------------- scoreboard ----------------
  logic [DW:0] exp_q[$];   // {last, data}
  logic [DW:0] exp_e;
  logic [DW:0] held;
  logic        held_v = 1'b0;
  int n_checks = 0;
  int n_pass = 0;
  int beats = 0;
  int outstanding = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      outstanding = 0;
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_last, bus.out_data} !== held)
          $display("FAIL hold_stable: got v=%b %h want v=1 %h", bus.out_valid, {bus.out_last, bus.out_data}, held);
        else n_pass++;
      end
      if (bram_en) outstanding++;
      if (bus.out_valid && bus.out_ready) begin
        outstanding--;
        beats++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat_unexpected: got %h want no beat", {bus.out_last, bus.out_data});
        end else begin
          exp_e = exp_q.pop_front();
          if ({bus.out_last, bus.out_data} !== exp_e)
            $display("FAIL beat_data: got last=%b data=%h want last=%b data=%h",
                     bus.out_last, bus.out_data, exp_e[DW], exp_e[DW-1:0]);
          else n_pass++;
        end
      end
      if (bram_en) begin
        n_checks++;
        if (outstanding > 2) $display("FAIL outstanding: got %0d want <=2", outstanding);
        else n_pass++;
      end
      held_v = bus.out_valid && !bus.out_ready;
      held   = {bus.out_last, bus.out_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_line(input logic [IW-1:0] idx);
    addr_t a;
    for (int w = 0; w < LW; w++) begin
      a = {idx, OW'(w)};
      exp_q.push_back({(w == LW - 1), mem[a]});
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  // (i.e. inside cycle 1 of the request).
  task automatic send_req(input logic [IW-1:0] idx);
    int k;
    bus.req_valid = 1'b1;
    bus.req_index = idx;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.req_ready) break;
    end
    n_checks++;
    if (k == 100) $display("FAIL req_accept: got no req_ready want req_ready within 100 cycles");
    else begin
      n_pass++;
      push_line(idx);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    n_checks++;
    if (busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL idle: got busy=%b pending=%0d want busy=0 pending=0", busy, exp_q.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.out_valid, bus.out_last, bram_en, busy} !== 5'b0)
      $display("FAIL reset_outputs: got rdy/v/last/en/busy=%b want 00000",
               {bus.req_ready, bus.out_valid, bus.out_last, bram_en, busy});
    else n_pass++;
    n_checks++;
    if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE);
    else n_pass++;
    n_checks++;
    if (bram_write_en !== '0) $display("FAIL write_en: got %h want 0", bram_write_en);
    else n_pass++;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", bus.req_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic exp_en;
    addr_t exp_addr;
    beats = 0;
    bus.out_ready = 1'b1;
    send_req(IW'(1));
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      exp_en = (k <= LW);
      n_checks++;
      if (bram_en !== exp_en) $display("FAIL basic_en c%0d: got %b want %b", k, bram_en, exp_en);
      else n_pass++;
      if (exp_en) begin
        exp_addr = 10'h010 + 10'(k - 1);
        n_checks++;
        if (bram_addr !== exp_addr) $display("FAIL basic_addr c%0d: got %h want %h", k, bram_addr, exp_addr);
        else n_pass++;
      end
      n_checks++;
      if (bus.out_valid !== (k >= 3 && k <= LW + 2))
        $display("FAIL basic_valid c%0d: got %b want %b", k, bus.out_valid, (k >= 3 && k <= LW + 2));
      else n_pass++;
      n_checks++;
      if (bus.out_last !== (k == LW + 2))
        $display("FAIL basic_last c%0d: got %b want %b", k, bus.out_last, (k == LW + 2));
      else n_pass++;
      n_checks++;
      if (bus.req_ready !== (k == LW + 3))
        $display("FAIL basic_ready c%0d: got %b want %b", k, bus.req_ready, (k == LW + 3));
      else n_pass++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (beats != LW) $display("FAIL basic_beats: got %0d want %0d", beats, LW);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_backpressure();
    int k;
    beats = 0;
    bus.out_ready = 1'b1;
    send_req(IW'(2));
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1) $display("FAIL bp_valid s%0d: got %b want 1", s, bus.out_valid);
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    wait_idle();
    n_checks++;
    if (beats != LW) $display("FAIL bp_beats: got %0d want %0d", beats, LW);
    else n_pass++;
  endtask

  task automatic test_toggle_ready();
    beats = 0;
    bus.out_ready = 1'b1;
    send_req(IW'(3));
    for (int k = 0; k < 200 && busy; k++) begin
      @(posedge clk); #1;
      bus.out_ready = ~bus.out_ready;
    end
    bus.out_ready = 1'b1;
    wait_idle();
    n_checks++;
    if (beats != LW) $display("FAIL toggle_beats: got %0d want %0d", beats, LW);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int k;
    bus.out_ready = 1'b1;
    send_req(IW'(4));
    bus.req_valid = 1'b1;
    bus.req_index = IW'(7);
    for (k = 1; k < 100; k++) begin
      @(negedge clk);
      if (bus.req_ready) break;
    end
    n_checks++;
    if (k != LW + 3) $display("FAIL b2b_accept_cycle: got %0d want %0d", k, LW + 3);
    else n_pass++;
    if (k < 100) push_line(IW'(7));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bram_en !== 1'b1 || bram_addr !== 10'h070)
      $display("FAIL b2b_first_issue: got en=%b addr=%h want en=1 addr=070", bram_en, bram_addr);
    else n_pass++;
    @(posedge clk); #1;
    wait_idle();
  endtask

  task automatic test_reset_mid_line();
    bus.out_ready = 1'b1;
    beats = 0;
    send_req(IW'(5));
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (beats >= 2) break;
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bram_en, busy, bus.req_ready} !== 4'b0)
      $display("FAIL midreset_outputs: got v/en/busy/rdy=%b want 0000",
               {bus.out_valid, bram_en, busy, bus.req_ready});
    else n_pass++;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", bus.req_ready);
    else n_pass++;
    @(posedge clk); #1;
    send_req(IW'(5));
    @(negedge clk);
    n_checks++;
    if (bram_en !== 1'b1 || bram_addr !== 10'h050)
      $display("FAIL midreset_restart: got en=%b addr=%h want en=1 addr=050", bram_en, bram_addr);
    else n_pass++;
    @(posedge clk); #1;
    wait_idle();
  endtask

  task automatic test_top_index();
    int n = 0;
    addr_t exp_addr;
    bus.out_ready = 1'b1;
    send_req(IW'(63));
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bram_en) begin
        exp_addr = 10'h3F0 + 10'(n);
        n_checks++;
        if (bram_addr !== exp_addr || n >= LW)
          $display("FAIL top_addr n%0d: got %h want %h", n, bram_addr, exp_addr);
        else n_pass++;
        n++;
      end
      if (!busy) break;
    end
    n_checks++;
    if (n != LW) $display("FAIL top_issues: got %0d want %0d", n, LW);
    else n_pass++;
    @(posedge clk); #1;
    wait_idle();
  endtask

  // ---------------- sequence ----------------
  initial begin
    bus.req_valid = 1'b0;
    bus.req_index = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom();
    for (int i = 0; i < LW; i++) mem[16 + i] = 32'hA0 + 32'(i);
    mem[10'h075] = 32'hDEADBEEF;

    test_reset();
    test_basic();
    test_backpressure();
    test_toggle_ready();
    test_back_to_back();
    test_reset_mid_line();
    test_top_index();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
